// File: rtl/llc_tag_responder.sv
// 4-way set-associative LLC tag array with pseudo-LRU replacement.
// One request at a time: IDLE -> LOOKUP (arrays commit) -> RESP (held until consumed).
package cache_define;
  localparam int ADDR_SIZE  = 32;
  localparam int CACHE_SIZE = 1024;
  localparam int ASSOC      = 4;
  localparam int CACHE_LINE = 64;
  localparam int INDEX      = CACHE_SIZE / (ASSOC * CACHE_LINE);
  localparam int INDEX_BITS = $clog2(INDEX);
  localparam int BYTE_BITS  = $clog2(CACHE_LINE);
  localparam int TAG_BITS   = ADDR_SIZE - INDEX_BITS - BYTE_BITS;
  localparam int LRU_BITS   = ASSOC - 1;
  localparam int WAY_BITS   = $clog2(ASSOC);
  localparam logic [1:0] HIT  = 2'd1;
  localparam logic [1:0] MISS = 2'd2;
endpackage

module llc_way_cmp
  import cache_define::*;
(
  input  logic                valid,
  input  logic [TAG_BITS-1:0] line_tag,
  input  logic [TAG_BITS-1:0] req_tag,
  output logic                hit
);
  assign hit = valid && (line_tag == req_tag);
endmodule

module llc_tag_responder
  import cache_define::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [1:0]           req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_result,
  output logic [1:0]           rsp_way,
  output logic                 rsp_evict,
  output logic                 rsp_writeback,
  output logic [TAG_BITS-1:0]  rsp_victim_tag
);
  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;
  state_t state_q, state_d;

  logic [INDEX-1:0][ASSOC-1:0][TAG_BITS-1:0] tag_q;
  logic [INDEX-1:0][ASSOC-1:0]               valid_q;
  logic [INDEX-1:0][ASSOC-1:0]               dirty_q;
  logic [INDEX-1:0][LRU_BITS-1:0]            plru_q;

  logic [TAG_BITS-1:0]   tag_r;
  logic [INDEX_BITS-1:0] idx_r;
  logic [1:0]            op_r;

  logic [ASSOC-1:0]                set_valid, set_dirty, hit_vec;
  logic [ASSOC-1:0][TAG_BITS-1:0]  set_tag;
  logic [LRU_BITS-1:0]             set_plru;
  logic                            hit, has_inv, is_write, is_inv, accept;
  logic [WAY_BITS-1:0]             hit_way, inv_way, plru_way, way_sel;

  logic [1:0]          res_d, way_d;
  logic                ev_d, wb_d;
  logic [TAG_BITS-1:0] vt_d;

  // Byte offset never participates in tag lookup.
  logic unused_byte_bits;
  assign unused_byte_bits = ^req_addr[BYTE_BITS-1:0];

  function automatic logic [LRU_BITS-1:0] plru_touch(input logic [LRU_BITS-1:0] p,
                                                     input logic [WAY_BITS-1:0] w);
    logic [LRU_BITS-1:0] n;
    n = p;
    case (w)
      2'd0: begin n[0] = 1'b1; n[1] = 1'b1; end
      2'd1: begin n[0] = 1'b1; n[1] = 1'b0; end
      2'd2: begin n[0] = 1'b0; n[2] = 1'b1; end
      default: begin n[0] = 1'b0; n[2] = 1'b0; end
    endcase
    return n;
  endfunction

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = LOOKUP;
      end
      LOOKUP: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign accept    = (state_q == IDLE) && req_valid;
  assign is_write  = (op_r == 2'b01);
  assign is_inv    = (op_r == 2'b10);
  assign set_valid = valid_q[idx_r];
  assign set_dirty = dirty_q[idx_r];
  assign set_tag   = tag_q[idx_r];
  assign set_plru  = plru_q[idx_r];

  for (genvar w = 0; w < ASSOC; w++) begin : g_way
    llc_way_cmp u_cmp (
      .valid    (set_valid[w]),
      .line_tag (set_tag[w]),
      .req_tag  (tag_r),
      .hit      (hit_vec[w])
    );
  end

  assign hit = |hit_vec;

  // Victim: lowest invalid way first, otherwise follow the PLRU tree.
  always_comb begin
    hit_way = '0;
    for (int w = 0; w < ASSOC; w++)
      if (hit_vec[w]) hit_way = WAY_BITS'(w);
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = ASSOC - 1; w >= 0; w--)
      if (!set_valid[w]) begin
        has_inv = 1'b1;
        inv_way = WAY_BITS'(w);
      end
    if (set_plru[0]) plru_way = set_plru[2] ? 2'd3 : 2'd2;
    else             plru_way = set_plru[1] ? 2'd1 : 2'd0;
    way_sel = hit ? hit_way : (has_inv ? inv_way : plru_way);
  end

  always_comb begin
    res_d = MISS;
    way_d = '0;
    ev_d  = 1'b0;
    wb_d  = 1'b0;
    vt_d  = '0;
    if (is_inv) begin
      if (hit) begin
        res_d = HIT;
        way_d = hit_way;
        wb_d  = set_dirty[hit_way];
        vt_d  = set_tag[hit_way];
      end
    end else if (hit) begin
      res_d = HIT;
      way_d = hit_way;
    end else begin
      way_d = way_sel;
      ev_d  = set_valid[way_sel];
      wb_d  = set_valid[way_sel] && set_dirty[way_sel];
      vt_d  = set_valid[way_sel] ? set_tag[way_sel] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_r <= '0;
      idx_r <= '0;
      op_r  <= '0;
    end else if (accept) begin
      tag_r <= req_addr[ADDR_SIZE-1 -: TAG_BITS];
      idx_r <= req_addr[BYTE_BITS +: INDEX_BITS];
      op_r  <= req_op;
    end
  end

  // Response registers are loaded on LOOKUP->RESP and cleared once consumed,
  // so every rsp_* reads 0 outside RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result     <= '0;
      rsp_way        <= '0;
      rsp_evict      <= 1'b0;
      rsp_writeback  <= 1'b0;
      rsp_victim_tag <= '0;
    end else if (state_q == LOOKUP) begin
      rsp_result     <= res_d;
      rsp_way        <= way_d;
      rsp_evict      <= ev_d;
      rsp_writeback  <= wb_d;
      rsp_victim_tag <= vt_d;
    end else if (state_q == RESP && rsp_ready) begin
      rsp_result     <= '0;
      rsp_way        <= '0;
      rsp_evict      <= 1'b0;
      rsp_writeback  <= 1'b0;
      rsp_victim_tag <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      plru_q  <= '0;
    end else if (state_q == LOOKUP) begin
      if (is_inv) begin
        if (hit) begin
          valid_q[idx_r][hit_way] <= 1'b0;
          dirty_q[idx_r][hit_way] <= 1'b0;
        end
      end else begin
        plru_q[idx_r] <= plru_touch(set_plru, way_sel);
        if (hit) begin
          if (is_write) dirty_q[idx_r][way_sel] <= 1'b1;
        end else begin
          tag_q[idx_r][way_sel]   <= tag_r;
          valid_q[idx_r][way_sel] <= 1'b1;
          dirty_q[idx_r][way_sel] <= is_write;
        end
      end
    end
  end
endmodule

// File: tb/tb_llc_tag_responder.sv
// Directed bench for llc_tag_responder: vector table plus stall and reset-abort sequences.
module tb_llc_tag_responder;
  logic        clk, rst_n, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_op, rsp_result, rsp_way;
  logic        rsp_evict, rsp_writeback;
  logic [23:0] rsp_victim_tag;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] RD = 2'b00, WR = 2'b01, INV = 2'b10, RD3 = 2'b11;
  localparam logic [1:0] H = 2'd1, M = 2'd2;

  typedef struct {
    logic        rst;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [1:0]  res;
    logic [1:0]  way;
    logic        ev;
    logic        wb;
    logic [23:0] vtag;
  } vec_t;

  vec_t vq[$];

  llc_tag_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_op         (req_op),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_result     (rsp_result),
    .rsp_way        (rsp_way),
    .rsp_evict      (rsp_evict),
    .rsp_writeback  (rsp_writeback),
    .rsp_victim_tag (rsp_victim_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_req(input string name, input logic [1:0] op, input logic [31:0] addr,
                         input logic [1:0] res, input logic [1:0] way, input logic ev,
                         input logic wb, input logic [23:0] vtag);
    int lat;
    req_valid = 1'b1;
    req_addr  = addr;
    req_op    = op;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"},  lat,            2);
    chk({name, " result"},   rsp_result,     res);
    chk({name, " way"},      rsp_way,        way);
    chk({name, " evict"},    rsp_evict,      ev);
    chk({name, " wb"},       rsp_writeback,  wb);
    chk({name, " vtag"},     rsp_victim_tag, vtag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    // rst, op, addr, result, way, evict, writeback, victim_tag
    vq.push_back('{1'b1, RD,  32'h0000_1000, M, 2'd0, 1'b0, 1'b0, 24'h0});
    vq.push_back('{1'b0, RD,  32'h0000_1000, H, 2'd0, 1'b0, 1'b0, 24'h0});
    vq.push_back('{1'b1, RD,  32'h0000_1000, M, 2'd0, 1'b0, 1'b0, 24'h0});
    vq.push_back('{1'b0, RD,  32'h0000_1100, M, 2'd1, 1'b0, 1'b0, 24'h0});
    vq.push_back('{1'b0, RD,  32'h0000_1200, M, 2'd2, 1'b0, 1'b0, 24'h0});
    vq.push_back('{1'b0, RD,  32'h0000_1300, M, 2'd3, 1'b0, 1'b0, 24'h0});
    vq.push_back('{1'b0, RD,  32'h0000_1400, M, 2'd0, 1'b1, 1'b0, 24'h10});
    vq.push_back('{1'b0, RD,  32'h0000_1100, H, 2'd1, 1'b0, 1'b0, 24'h0});
    vq.push_back('{1'b0, RD,  32'h0000_1500, M, 2'd2, 1'b1, 1'b0, 24'h12});
    vq.push_back('{1'b0, WR,  32'h0000_1300, H, 2'd3, 1'b0, 1'b0, 24'h0});
    vq.push_back('{1'b0, RD,  32'h0000_1600, M, 2'd0, 1'b1, 1'b0, 24'h14});
    vq.push_back('{1'b0, RD,  32'h0000_1700, M, 2'd2, 1'b1, 1'b0, 24'h15});
    vq.push_back('{1'b0, RD,  32'h0000_1800, M, 2'd1, 1'b1, 1'b0, 24'h11});
    vq.push_back('{1'b0, RD,  32'h0000_1900, M, 2'd3, 1'b1, 1'b1, 24'h13});
    vq.push_back('{1'b0, RD3, 32'h0000_193f, H, 2'd3, 1'b0, 1'b0, 24'h0});
    vq.push_back('{1'b1, WR,  32'h0000_2040, M, 2'd0, 1'b0, 1'b0, 24'h0});
    vq.push_back('{1'b0, INV, 32'h0000_2040, H, 2'd0, 1'b0, 1'b1, 24'h20});
    vq.push_back('{1'b0, RD,  32'h0000_2040, M, 2'd0, 1'b0, 1'b0, 24'h0});
    vq.push_back('{1'b0, INV, 32'h0000_2040, H, 2'd0, 1'b0, 1'b0, 24'h20});
    vq.push_back('{1'b0, INV, 32'h0000_3040, M, 2'd0, 1'b0, 1'b0, 24'h0});

    rst_n     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_addr  = '0;
    req_op    = '0;
    #12;
    chk("reset req_ready",  req_ready,      1);
    chk("reset rsp_valid",  rsp_valid,      0);
    chk("reset rsp_result", rsp_result,     0);
    chk("reset rsp_vtag",   rsp_victim_tag, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].rst) do_reset();
      run_req($sformatf("v%0d", i), vq[i].op, vq[i].addr, vq[i].res, vq[i].way,
              vq[i].ev, vq[i].wb, vq[i].vtag);
    end

    // Stalled response: outputs hold, new requests are ignored.
    do_reset();
    req_valid = 1'b1;
    req_addr  = 32'h0000_1000;
    req_op    = RD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1;
      req_addr  = 32'h0000_5000;
      req_op    = WR;
      chk($sformatf("stall%0d rsp_valid", c), rsp_valid,  1);
      chk($sformatf("stall%0d result", c),    rsp_result, M);
      chk($sformatf("stall%0d way", c),       rsp_way,    0);
      chk($sformatf("stall%0d req_ready", c), req_ready,  0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("stall release rsp_valid", rsp_valid,  0);
    chk("stall release req_ready", req_ready,  1);
    chk("stall release result",    rsp_result, 0);
    run_req("after stall", RD, 32'h0000_5000, M, 2'd1, 1'b0, 1'b0, 24'h0);

    // Reset during RESP drops the response and the cached line.
    req_valid = 1'b1;
    req_addr  = 32'h0000_1000;
    req_op    = RD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort pre rsp_valid", rsp_valid, 1);
    chk("abort pre result",    rsp_result, H);
    rst_n = 1'b0;
    #1;
    chk("abort rsp_valid", rsp_valid,  0);
    chk("abort req_ready", req_ready,  1);
    chk("abort result",    rsp_result, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_req("after abort", RD, 32'h0000_1000, M, 2'd0, 1'b0, 1'b0, 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/llc_tag_responder.md
LLC_TAG_RESPONDER -- requirements
Module: llc_tag_responder

Interface
REQ-001 Parameters SHALL come from cache_define: ADDR_SIZE=32, CACHE_SIZE=1024, ASSOC=4, CACHE_LINE=64; derived INDEX=4 sets, INDEX_BITS=2, BYTE_BITS=6, TAG_BITS=24, LRU_BITS=3, HIT=1, MISS=2.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 req_valid  in  1  request offered.
REQ-005 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-006 req_addr  in  ADDR_SIZE  byte address; tag=[31:8], index=[7:6], byte offset=[5:0] ignored.
REQ-007 req_op  in  2  00 read, 01 write, 10 invalidate, 11 treated as read.
REQ-008 rsp_valid  out  1  response present.
REQ-009 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-010 rsp_result  out  2  HIT (1) or MISS (2); 0 when rsp_valid=0.
REQ-011 rsp_way  out  2  way hit, allocated, or invalidated.
REQ-012 rsp_evict  out  1  a valid line was replaced.
REQ-013 rsp_writeback  out  1  the removed line was dirty.
REQ-014 rsp_victim_tag  out  TAG_BITS  tag of the removed line; 0 otherwise.

Function
REQ-015 Storage SHALL be per set/way tag[24], valid, dirty, plus a 3-bit pseudo-LRU tree per set (b0 root, b1 ways 0/1, b2 ways 2/3).
REQ-016 FSM states SHALL be IDLE, LOOKUP, RESP: IDLE->LOOKUP on the request handshake; LOOKUP->RESP unconditionally; RESP->IDLE on the response handshake.
REQ-017 req_ready SHALL be 1 only in IDLE; the request fields SHALL be registered at the handshake.
REQ-018 Latency: request handshake in cycle N SHALL give rsp_valid=1 in cycle N+2; the next request SHALL be accepted no earlier than the cycle after the response handshake.
REQ-019 In RESP all rsp_* outputs SHALL be registered and held stable until rsp_ready=1.
REQ-020 Hit: a way in the indexed set with valid=1 and a matching tag; at most one way SHALL match.
REQ-021 Victim on miss SHALL be the lowest-index invalid way; with none invalid, the PLRU way: b0=0 selects left (b1=0 way0, b1=1 way1), b0=1 selects right (b2=0 way2, b2=1 way3).
REQ-022 PLRU update on a hit or allocate to way w SHALL point away from w: way0 sets b0=1,b1=1; way1 sets b0=1,b1=0; way2 sets b0=0,b2=1; way3 sets b0=0,b2=0; other bits unchanged.
REQ-023 Read/write hit SHALL give result HIT, way=w, evict=0, writeback=0; a write SHALL set dirty; PLRU SHALL be updated.
REQ-024 Read/write miss SHALL allocate the victim: tag installed, valid=1, dirty=(op==write), PLRU updated.
REQ-025 On a miss, evict SHALL equal the victim's old valid, writeback SHALL equal evict && old dirty, and victim_tag SHALL be the old tag if evict=1, else 0.
REQ-026 Invalidate hit SHALL give result HIT, way=w, valid=0, dirty=0, evict=0, writeback=old dirty, victim_tag=old tag, with no PLRU change.
REQ-027 Invalidate miss SHALL give result MISS with no state change; way, evict, writeback and victim_tag SHALL be 0.
REQ-028 Array and PLRU updates SHALL commit at the LOOKUP->RESP edge, so the next request observes them.
REQ-029 Requests offered outside IDLE SHALL be ignored, with no state effect.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE and clear all valid, dirty, tag and PLRU bits to 0.
REQ-031 During reset, rsp_* outputs SHALL be 0 and req_ready SHALL be 1 (IDLE).
REQ-032 Reset mid-operation (LOOKUP or RESP) SHALL abort the transaction with no response delivered; uncommitted updates SHALL be lost.

Verification
REQ-033 After reset, read 0x00001000 -> MISS, way0, evict=0. A second read -> HIT, way0; rsp_valid is 2 cycles after each request handshake.
REQ-034 After reset, reads 0x1000, 0x1100, 0x1200, 0x1300 -> MISS on ways 0..3, evict=0. Then read 0x1400 -> MISS, way0, evict=1, victim_tag=0x000010, writeback=0.
REQ-035 Write 0x2040 -> MISS, way0, set1 dirty. Invalidate 0x2040 -> HIT, way0, writeback=1, victim_tag=0x000020. Read 0x2040 -> MISS, way0, evict=0.
REQ-036 Hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0, and a new req_valid is ignored. Raise rsp_ready -> IDLE the next cycle.
REQ-037 Read 0x1000, then pull rst_n low during RESP -> rsp_valid=0 at once. After release, read 0x1000 -> MISS, way0.
